// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM pipeline stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;

  modport master (
    output MemRead, MemWrite, addr, wd,
    input  rd, ready, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wd,
    output rd, ready, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed single-port data memory with WAIT programmable wait states;
// pulses ready for one cycle on completion and flags illegal accesses.
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_C = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        rd_op_q;
  logic        wr_op_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] rd_q;
  logic        err_q;

  // NOTE: the array has no reset term so it maps onto plain RAM; contents
  // survive rst by design.
  logic [31:0] mem_q [DEPTH];

  logic          req;
  logic          acc_go;
  logic          acc_rd;
  logic          acc_wr;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wd;
  logic          acc_err;
  logic [AW-1:0] acc_idx;

  assign req = bus.MemRead | bus.MemWrite;

  // The access happens on the edge that enters DONE. With WAIT==0 that edge
  // is also the sampling edge, so the live inputs are used instead of the
  // latched copy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    acc_go   = 1'b0;
    acc_rd   = rd_op_q;
    acc_wr   = wr_op_q;
    acc_addr = addr_q;
    acc_wd   = wd_q;
    if (state_q == IDLE && WAIT_C == 4'd0 && req) begin
      acc_go   = 1'b1;
      acc_rd   = bus.MemRead;
      acc_wr   = bus.MemWrite;
      acc_addr = bus.addr;
      acc_wd   = bus.wd;
    end else if (state_q == BUSY && cnt_q == 4'd1) begin
      acc_go = 1'b1;
    end
    if (rst) begin
      acc_go = 1'b0;
    end
  end

  assign acc_err = (acc_addr[1:0] != 2'b00) | (|acc_addr[31:AW+2]) | (acc_rd & acc_wr);
  assign acc_idx = acc_addr[AW+1:2];

  always_ff @(posedge clk) begin
    if (acc_go && acc_wr && !acc_err) begin
      mem_q[acc_idx] <= acc_wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_op_q <= 1'b0;
      wr_op_q <= 1'b0;
      addr_q  <= 32'd0;
      wd_q    <= 32'd0;
      rd_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      unique case (state_q)
        IDLE: begin
          if (req) begin
            rd_op_q <= bus.MemRead;
            wr_op_q <= bus.MemWrite;
            addr_q  <= bus.addr;
            wd_q    <= bus.wd;
            cnt_q   <= WAIT_C;
            state_q <= (WAIT_C == 4'd0) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      // rd and err only move on completion; errors force rd to zero.
      if (acc_go) begin
        if (acc_err) begin
          rd_q  <= 32'd0;
          err_q <= 1'b1;
        end else begin
          err_q <= 1'b0;
          if (acc_rd) begin
            rd_q <= mem_q[acc_idx];
          end
        end
      end
    end
  end

  assign bus.ready = (state_q == DONE);
  assign bus.rd    = rd_q;
  assign bus.err   = err_q;

endmodule
